// File: rtl/apb_master_ctrl_pkg.sv
// Shared types and constants for the APB initiator and the register slaves on its segment.
package apb_master_ctrl_pkg;

    // Transfer sequencing states of the APB initiator.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Default bus geometry of the segment.
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Register offsets of the configuration/status slaves on the segment.
    localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS = 32'h0000_0004;
    localparam logic [31:0] REG_IRQ    = 32'h0000_0008;
    localparam logic [31:0] REG_ERR    = 32'h0000_000C;

    // Width of a counter able to hold values 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int unsigned max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake plus APB3 bus of the initiator, seen from both ends.
interface apb_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // local request channel
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [DATA_W-1:0] req_wdata;
    // local response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    // APB3 bus
    logic [ADDR_W-1:0] m_paddr;
    logic              m_psel;
    logic              m_penable;
    logic              m_pwrite;
    logic [DATA_W-1:0] m_pwdata;
    logic [DATA_W-1:0] m_prdata;
    logic              m_pready;
    logic              m_pslverr;

    // The initiator itself.
    modport master (
        input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
        input  m_prdata, m_pready, m_pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output m_paddr, m_psel, m_penable, m_pwrite, m_pwdata
    );

    // Everything around it: the local controller and the APB slaves.
    modport slave (
        output req_valid, req_addr, req_write, req_wdata, rsp_ready,
        output m_prdata, m_pready, m_pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  m_paddr, m_psel, m_penable, m_pwrite, m_pwdata
    );
endinterface

// File: rtl/apb_master_ctrl_wait_timer.sv
// Wait-state counter for the ACCESS phase. 'expired' is registered and is high once
// TIMEOUT wait cycles have been counted, so the following ACCESS cycle without pready
// aborts. TIMEOUT = 0 disables expiry. The counter saturates instead of wrapping.
module apb_wait_timer
    import apb_master_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W     = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam bit               TIMER_EN  = (TIMEOUT != 32'd0);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             expired_r;

    // Next count: clear has priority, otherwise count wait cycles up to saturation.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clear) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (enable && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and expiry flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r     <= {CNT_W{1'b0}};
            expired_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            expired_r <= TIMER_EN && (cnt_nxt_s == CNT_LIMIT);
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 initiator: turns one local request at a time into a SETUP/ACCESS transfer and
// returns the slave's answer (or a timeout abort) on the response handshake.
// All bus and response outputs come straight from registers.
module apb_master_ctrl
    import apb_master_ctrl_pkg::*;
#(
    parameter int          ADDR_W  = APB_ADDR_W,
    parameter int          DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rstn,
    apb_master_ctrl_if.master  bus
);

    apb_state_e        state_r,       state_nxt_s;
    logic              req_ready_r,   req_ready_nxt_s;
    logic              rsp_valid_r,   rsp_valid_nxt_s;
    logic [DATA_W-1:0] rsp_rdata_r,   rsp_rdata_nxt_s;
    logic              rsp_err_r,     rsp_err_nxt_s;
    logic              rsp_timeout_r, rsp_timeout_nxt_s;
    logic [ADDR_W-1:0] paddr_r,       paddr_nxt_s;
    logic              psel_r,        psel_nxt_s;
    logic              penable_r,     penable_nxt_s;
    logic              pwrite_r,      pwrite_nxt_s;
    logic [DATA_W-1:0] pwdata_r,      pwdata_nxt_s;

    logic timer_clear_s;
    logic timer_enable_s;
    logic timer_expired_s;

    // The wait counter runs only on ACCESS cycles without pready and restarts when the
    // response has been consumed.
    assign timer_enable_s = (state_r == ST_ACCESS) && !bus.m_pready;
    assign timer_clear_s  = (state_r == ST_RESP) && bus.rsp_ready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (timer_clear_s),
        .enable  (timer_enable_s),
        .expired (timer_expired_s)
    );

    // Next-state and next-output logic; every register holds unless its state says otherwise.
    always_comb begin
        state_nxt_s       = state_r;
        req_ready_nxt_s   = req_ready_r;
        rsp_valid_nxt_s   = rsp_valid_r;
        rsp_rdata_nxt_s   = rsp_rdata_r;
        rsp_err_nxt_s     = rsp_err_r;
        rsp_timeout_nxt_s = rsp_timeout_r;
        paddr_nxt_s       = paddr_r;
        psel_nxt_s        = psel_r;
        penable_nxt_s     = penable_r;
        pwrite_nxt_s      = pwrite_r;
        pwdata_nxt_s      = pwdata_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    // Reads drive zero on pwdata so no stale write data appears on the bus.
                    paddr_nxt_s     = bus.req_addr;
                    pwrite_nxt_s    = bus.req_write;
                    pwdata_nxt_s    = bus.req_write ? bus.req_wdata : {DATA_W{1'b0}};
                    psel_nxt_s      = 1'b1;
                    penable_nxt_s   = 1'b0;
                    req_ready_nxt_s = 1'b0;
                    state_nxt_s     = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SETUP: begin
                penable_nxt_s = 1'b1;
                state_nxt_s   = ST_ACCESS;
            end

            ST_ACCESS: begin
                // pready takes precedence over an expiry in the same cycle.
                if (bus.m_pready) begin
                    rsp_rdata_nxt_s   = pwrite_r ? {DATA_W{1'b0}} : bus.m_prdata;
                    rsp_err_nxt_s     = bus.m_pslverr;
                    rsp_timeout_nxt_s = 1'b0;
                    rsp_valid_nxt_s   = 1'b1;
                    psel_nxt_s        = 1'b0;
                    penable_nxt_s     = 1'b0;
                    state_nxt_s       = ST_RESP;
                end else if (timer_expired_s) begin
                    rsp_rdata_nxt_s   = {DATA_W{1'b0}};
                    rsp_err_nxt_s     = 1'b1;
                    rsp_timeout_nxt_s = 1'b1;
                    rsp_valid_nxt_s   = 1'b1;
                    psel_nxt_s        = 1'b0;
                    penable_nxt_s     = 1'b0;
                    state_nxt_s       = ST_RESP;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end

            ST_RESP: begin
                // Response fields stay frozen until consumed; no request is taken here.
                if (bus.rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
                    req_ready_nxt_s = 1'b1;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end

            default: begin
                state_nxt_s       = ST_IDLE;
                req_ready_nxt_s   = 1'b1;
                rsp_valid_nxt_s   = 1'b0;
                rsp_rdata_nxt_s   = {DATA_W{1'b0}};
                rsp_err_nxt_s     = 1'b0;
                rsp_timeout_nxt_s = 1'b0;
                psel_nxt_s        = 1'b0;
                penable_nxt_s     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the bus and discards any pending response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= ST_IDLE;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            paddr_r       <= {ADDR_W{1'b0}};
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            pwdata_r      <= {DATA_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            req_ready_r   <= req_ready_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_rdata_r   <= rsp_rdata_nxt_s;
            rsp_err_r     <= rsp_err_nxt_s;
            rsp_timeout_r <= rsp_timeout_nxt_s;
            paddr_r       <= paddr_nxt_s;
            psel_r        <= psel_nxt_s;
            penable_r     <= penable_nxt_s;
            pwrite_r      <= pwrite_nxt_s;
            pwdata_r      <= pwdata_nxt_s;
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.m_paddr     = paddr_r;
    assign bus.m_psel      = psel_r;
    assign bus.m_penable   = penable_r;
    assign bus.m_pwrite    = pwrite_r;
    assign bus.m_pwdata    = pwdata_r;

endmodule
